pipe_scheduler: RTL



---
 rtl/pipe_scheduler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: shares one external fixed-latency pipelined datapath among
// N_REQ requesters. Picks one requester per cycle, feeds its operand into the
// datapath, and carries valid/ID tokens alongside so each result comes back
// tagged with its requester. A full output stage with no consumer stalls the
// whole pipeline through dp_en.
//
// Build option: define PIPE_SCHED_FIXED_PRIO_EN to replace round-robin
// arbitration with fixed priority (lowest index wins, no rotation pointer).
module pipe_scheduler #(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = 8,
  parameter int LATENCY = 8,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic                   dp_en,
  output logic [WIDTH-1:0]       dp_in,
  input  logic [WIDTH-1:0]       dp_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id
);

  // Token pipeline, one entry per datapath stage.
  logic [LATENCY-1:0] vld_q;
  logic [ID_W-1:0]    id_q [LATENCY];

  logic               found;
  logic [ID_W-1:0]    grant;
  logic               accept;

`ifndef PIPE_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0]    rr_q;
`endif

  // The datapath and the token pipeline move together; a held result freezes
  // everything behind it, bubbles included. Reset also freezes the datapath.
  assign dp_en = en & ~rst & ~(vld_q[LATENCY-1] & ~rsp_ready);

  // Pick the winning requester for this cycle.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no
    // path leaves it unassigned and no latch is inferred.
    found = 1'b0;
    grant = '0;
`ifndef PIPE_SCHED_FIXED_PRIO_EN
    // First pass: indices at or above the pointer, in ascending order.
    for (int r = 0; r < N_REQ; r++) begin
      if (!found && req_valid[r] && (ID_W'(r) >= rr_q)) begin
        found = 1'b1;
        grant = ID_W'(r);
      end
    end
`endif
    // Second pass (or the only pass for fixed priority): wrap to index 0.
    for (int r = 0; r < N_REQ; r++) begin
      if (!found && req_valid[r]) begin
        found = 1'b1;
        grant = ID_W'(r);
      end
    end
  end

  // A grant only turns into a transfer when the pipeline is advancing.
  assign accept = dp_en & found;

  // Drive the one-hot accept and steer the winner's operand into the datapath.
  always_comb begin
    req_ready = '0;
    dp_in     = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (accept && (grant == ID_W'(r))) begin
        req_ready[r] = 1'b1;
        dp_in        = req_data[r*WIDTH +: WIDTH];
      end
    end
  end

  // Advance valid/ID tokens in lockstep with the datapath stages.
  always_ff @(posedge clk) begin
    // NOTE: the token arrays are state that decides rsp_valid, so unlike a
    // plain data buffer they must be cleared on reset; in-flight work is
    // dropped and the shared datapath is reset with the same signal.
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) id_q[k] <= '0;
    end else if (dp_en) begin
      // NOTE: non-blocking assignments make every stage load the value its
      // predecessor held before the edge, giving a true shift register.
      vld_q[0] <= accept;
      id_q[0]  <= grant;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
      end
    end
  end

`ifndef PIPE_SCHED_FIXED_PRIO_EN
  // Rotate the round-robin pointer past the requester just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if (accept) begin
      rr_q <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end
`endif

  assign rsp_valid = vld_q[LATENCY-1];
  assign rsp_id    = id_q[LATENCY-1];
  assign rsp_data  = dp_out;

endmodule
